apb_rr_arbiter: RTL and testbench



---
 rtl/apb_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ APB requesters.
// Optional watchdog in ACCESS is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned AW_APB         = 32,
  parameter int unsigned DW_APB         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      apb_clk,
  input  logic                      sys_reset,
  input  logic [NUM_REQ-1:0]        s_psel,
  input  logic [NUM_REQ-1:0]        s_penable,
  input  logic [NUM_REQ-1:0]        s_pwrite,
  input  logic [NUM_REQ*AW_APB-1:0] s_paddr,
  input  logic [NUM_REQ*DW_APB-1:0] s_pwdata,
  output logic [NUM_REQ-1:0]        s_pready,
  output logic [DW_APB-1:0]         s_prdata,
  output logic [NUM_REQ-1:0]        s_pslverr,
  output logic                      m_psel,
  output logic                      m_penable,
  output logic                      m_pwrite,
  output logic [AW_APB-1:0]         m_paddr,
  output logic [DW_APB-1:0]         m_pwdata,
  input  logic                      m_pready,
  input  logic                      m_pslverr,
  input  logic [DW_APB-1:0]         m_prdata,
  output logic [GW-1:0]             grant_idx,
  output logic                      busy
`ifdef APB_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_flag
`endif
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q;

  logic              any_req;
  logic [GW-1:0]     win_idx;
  logic              win_write;
  logic [AW_APB-1:0] win_addr;
  logic [DW_APB-1:0] win_wdata;

  // Search starts one past the last owner, so the last owner ends up lowest priority.
  always_comb begin
    any_req = 1'b0;
    win_idx = grant_idx;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!any_req && s_psel[GW'((32'(grant_idx) + k) % NUM_REQ)]) begin
        any_req = 1'b1;
        win_idx = GW'((32'(grant_idx) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) begin
        win_write = s_pwrite[i];
        win_addr  = s_paddr[i*AW_APB +: AW_APB];
        win_wdata = s_pwdata[i*DW_APB +: DW_APB];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] to_cnt_q;
`endif

  always_ff @(posedge apb_clk) begin
    if (sys_reset) begin
      state_q   <= StIdle;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      s_pready  <= '0;
      s_pslverr <= '0;
      s_prdata  <= '0;
      grant_idx <= GW'(NUM_REQ - 1);
      busy      <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_idx <= win_idx;
            m_pwrite  <= win_write;
            m_paddr   <= win_addr;
            m_pwdata  <= win_wdata;
            m_psel    <= 1'b1;
            m_penable <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          m_penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          to_cnt_q  <= '0;
`endif
          state_q   <= StAccess;
        end
        StAccess: begin
          if (m_pready) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            s_pready  <= NUM_REQ'(1) << grant_idx;
            s_pslverr <= m_pslverr ? (NUM_REQ'(1) << grant_idx) : '0;
            s_prdata  <= m_pwrite ? '0 : m_prdata;
            state_q   <= StResp;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the stalled slave and answer the requester with an error.
            m_psel       <= 1'b0;
            m_penable    <= 1'b0;
            s_pready     <= NUM_REQ'(1) << grant_idx;
            s_pslverr    <= NUM_REQ'(1) << grant_idx;
            s_prdata     <= '0;
            timeout_flag <= 1'b1;
            state_q      <= StResp;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          s_pready  <= '0;
          s_pslverr <= '0;
          busy      <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
          timeout_flag <= 1'b0;
`endif
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The grant deliberately ignores the requester's own phase.
  logic unused_inputs;
`ifdef APB_ARB_TIMEOUT_EN
  assign unused_inputs = ^s_penable;
`else
  assign unused_inputs = ^{s_penable, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Randomized bench for apb_rr_arbiter: random requesters and a random-wait slave,
// checked against a transaction-level round-robin reference model.
module tb_apb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = $clog2(N);

  logic              apb_clk = 1'b0;
  logic              sys_reset;
  logic [N-1:0]      s_psel, s_penable, s_pwrite;
  logic [N*AW-1:0]   s_paddr;
  logic [N*DW-1:0]   s_pwdata;
  logic [N-1:0]      s_pready, s_pslverr;
  logic [DW-1:0]     s_prdata;
  logic              m_psel, m_penable, m_pwrite;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic              m_pready, m_pslverr;
  logic [DW-1:0]     m_prdata;
  logic [GW-1:0]     grant_idx;
  logic              busy;
`ifdef APB_ARB_TIMEOUT_EN
  logic              timeout_flag;
`endif

  apb_rr_arbiter #(
    .NUM_REQ(N), .AW_APB(AW), .DW_APB(DW), .TIMEOUT_CYCLES(256)
  ) dut (
    .apb_clk(apb_clk), .sys_reset(sys_reset),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .grant_idx(grant_idx), .busy(busy)
`ifdef APB_ARB_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  always #5 apb_clk = ~apb_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Requester agents
  bit          act[N];
  bit          r_wr[N];
  logic [31:0] r_addr[N], r_data[N];
  int          age[N];
  int          max_age = 0;
  int          served  = 0;

  // Slave memory and reference memory (16 words, word-aligned addresses)
  logic [31:0] smem[16];
  logic [31:0] ref_mem[16];

  // Reference-model and previous-cycle observations
  int          exp_last;
  int          owner;
  int          waits, waited;
  bit          s_err;
  bit          p_idle, p_setup, p_access, p_mready, p_err, p_write;
  logic [31:0] p_addr, p_wdata;
  logic [N-1:0] p_psel;

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic drive_requesters();
    for (int i = 0; i < N; i++) begin
      s_psel[i]              = act[i];
      s_penable[i]           = act[i] && (age[i] > 0);
      s_pwrite[i]            = r_wr[i];
      s_paddr[i*AW +: AW]    = r_addr[i];
      s_pwdata[i*DW +: DW]   = r_data[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; age[i] = 0; r_wr[i] = 0; r_addr[i] = '0; r_data[i] = '0;
    end
    exp_last = N - 1; owner = 0; waits = 0; waited = 0; s_err = 0;
    p_idle = 1; p_setup = 0; p_access = 0; p_mready = 0; p_err = 0; p_write = 0;
    p_addr = '0; p_wdata = '0;
    m_pready = 0; m_pslverr = 0; m_prdata = '0;
    drive_requesters();
    p_psel = s_psel;
  endtask

  task automatic cycle();
    int w;
    @(posedge apb_clk);
    #1;
    // Slave side effect of a transfer that completed on this edge
    if (p_access && p_mready && p_write && !p_err) smem[p_addr[5:2]] = p_wdata;

    if (p_access && p_mready) begin
      check_eq("resp_pready", s_pready, N'(1) << owner);
      check_eq("resp_pslverr", s_pslverr, p_err ? (N'(1) << owner) : '0);
      check_eq("resp_prdata", s_prdata, r_wr[owner] ? 32'h0 : ref_mem[r_addr[owner][5:2]]);
      check_eq("resp_mpsel_drop", {m_psel, m_penable}, 2'b00);
      if (r_wr[owner] && !p_err) ref_mem[r_addr[owner][5:2]] = r_data[owner];
      act[owner] = 0;
      served++;
    end else begin
      check_eq("no_resp", {s_pready, s_pslverr}, '0);
    end

    check_eq("busy", busy, m_psel || (|s_pready));

    if (p_idle) begin
      check_eq("grant_start", {m_psel, m_penable}, (p_psel != '0) ? 2'b10 : 2'b00);
      if (p_psel != '0) begin
        w = rr_pick(exp_last, p_psel);
        check_eq("grant_idx", grant_idx, w);
        check_eq("setup_paddr", m_paddr, r_addr[w]);
        check_eq("setup_pwrite", m_pwrite, r_wr[w]);
        if (r_wr[w]) check_eq("setup_pwdata", m_pwdata, r_data[w]);
        owner = w; exp_last = w;
        waits = $urandom_range(0, 3); waited = 0;
        s_err = ($urandom_range(0, 4) == 0);
      end
    end
    if (p_setup || (p_access && !p_mready)) begin
      check_eq("access_ctrl", {m_psel, m_penable}, 2'b11);
      check_eq("access_hold", m_paddr, p_addr);
    end

    // Slave response for the coming edge
    if (m_psel && m_penable && waited == waits) begin
      m_pready = 1; m_pslverr = s_err; m_prdata = smem[m_paddr[5:2]];
    end else begin
      if (m_psel && m_penable) waited++;
      m_pready = $urandom_range(0, 1) == 0 ? 1'b0 : !(m_psel && m_penable);
      m_pslverr = $urandom_range(0, 1) == 1;
      m_prdata = $urandom;
    end

    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        age[i]++;
        if (age[i] > max_age) max_age = age[i];
      end else if ($urandom_range(0, 2) == 0) begin
        act[i] = 1; age[i] = 0;
        r_addr[i] = 32'($urandom_range(0, 15)) << 2;
        r_wr[i] = $urandom_range(0, 1) == 1;
        r_data[i] = $urandom;
      end
    end
    drive_requesters();

    p_idle   = !(m_psel || (|s_pready));
    p_setup  = m_psel && !m_penable;
    p_access = m_psel && m_penable;
    p_mready = m_pready;
    p_err    = m_pslverr;
    p_write  = m_pwrite;
    p_addr   = m_paddr;
    p_wdata  = m_pwdata;
    p_psel   = s_psel;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    model_reset();
    sys_reset = 1;
    repeat (2) @(posedge apb_clk);
    #1;
    check_eq("rst_grant_idx", grant_idx, N - 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mctrl", {m_psel, m_penable, m_pwrite}, 3'b000);
    check_eq("rst_maddr_wdata", {m_paddr, m_pwdata}, '0);
    check_eq("rst_sresp", {s_pready, s_pslverr, s_prdata}, '0);
    sys_reset = 0;

    repeat (500) cycle();

    // Reset while a transfer sits in ACCESS
    found = 0;
    for (int t = 0; t < 60 && !found; t++) begin
      cycle();
      found = m_psel && m_penable;
    end
    check_eq("reach_access", found, 1);
    m_pready = 0;
    sys_reset = 1;
    @(posedge apb_clk);
    #1;
    check_eq("midrst_mctrl", {m_psel, m_penable}, 2'b00);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_grant_idx", grant_idx, N - 1);
    check_eq("midrst_sresp", {s_pready, s_pslverr}, '0);
    sys_reset = 0;
    model_reset();

    repeat (400) cycle();

    check_eq("progress", served > 40, 1);
    check_eq("bounded_wait", max_age <= 40, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
